// File: rtl/dec_scan_n_if.sv
// Handshake / bus bundle for the dec_scan_n line decoder.
//   master : host side  - drives en, mode, w, w_valid; observes w_ready, y, sel, step
//   slave  : decoder    - observes en, mode, w, w_valid; drives w_ready, y, sel, step
// Signals:
//   en       enable; 0 forces all lines inactive
//   mode     0 = DIRECT (host-loaded index), 1 = SCAN (internal stepping)
//   w        select index for DIRECT mode
//   w_valid  w is valid
//   w_ready  decoder can accept w this cycle
//   y        decoded lines (OUTS = 2**N)
//   sel      index currently decoded
//   step     one-cycle pulse when sel/y take a new index
interface dec_scan_n_if #(
  parameter int N = 2
) ();
  localparam int OUTS = 2 ** N;

  logic            en;
  logic            mode;
  logic [N-1:0]    w;
  logic            w_valid;
  logic            w_ready;
  logic [OUTS-1:0] y;
  logic [N-1:0]    sel;
  logic            step;

  modport master (
    output en, mode, w, w_valid,
    input  w_ready, y, sel, step
  );

  modport slave (
    input  en, mode, w, w_valid,
    output w_ready, y, sel, step
  );
endinterface

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with enable and two modes:
//   DIRECT - the host loads a select index over a valid/ready handshake.
//   SCAN   - an internal counter walks the active line through all outputs,
//            holding each one for DWELL clocks.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   bus    dec_scan_n_if.slave (en, mode, w, w_valid in; w_ready, y, sel, step out)
// Parameters:
//   N          select width, output width OUTS = 2**N
//   DWELL      clocks per line in SCAN mode (>= 1)
//   ACTIVE_LOW 1 inverts y (active line = 0)
module dec_scan_n #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  dec_scan_n_if.slave   bus
);
  localparam int OUTS = 2 ** N;
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  // XOR mask applied to active-high one-hot patterns to get the output polarity
  localparam logic [OUTS-1:0] POL_MASK   = {OUTS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    sel_q;
  logic [DW-1:0]   dwell_q;
  logic [OUTS-1:0] y_q;
  logic            step_q;

  // Natural N-bit overflow gives the OUTS-1 -> 0 wrap
  logic [N-1:0]    sel_inc;
  assign sel_inc = sel_q + 1'b1;

  // One-hot decodes of the three indices y can be loaded from
  logic [OUTS-1:0] oh_w;
  logic [OUTS-1:0] oh_sel;
  logic [OUTS-1:0] oh_inc;

  generate
    for (genvar gi = 0; gi < OUTS; gi++) begin : g_dec
      assign oh_w[gi]   = (bus.w   == N'(gi));
      assign oh_sel[gi] = (sel_q   == N'(gi));
      assign oh_inc[gi] = (sel_inc == N'(gi));
    end
  endgenerate

  assign bus.w_ready = bus.en & ~bus.mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dwell_q <= '0;
      y_q     <= POL_MASK;
      step_q  <= 1'b0;
    end else if (!bus.en) begin
      // Disable wins over everything; sel is kept for a later resume
      state_q <= IDLE;
      dwell_q <= '0;
      y_q     <= POL_MASK;
      step_q  <= 1'b0;
    end else if (!bus.mode) begin
      state_q <= DIRECT;
      dwell_q <= '0;
      if (bus.w_valid) begin
        sel_q  <= bus.w;
        y_q    <= oh_w ^ POL_MASK;
        step_q <= 1'b1;
      end else begin
        // No transfer: y and sel hold (inactive if coming from IDLE,
        // last scanned line if coming from SCAN)
        step_q <= 1'b0;
      end
    end else begin
      state_q <= SCAN;
      if (state_q != SCAN) begin
        // Entry edge shows the current index without advancing it and
        // starts a fresh dwell period
        y_q     <= oh_sel ^ POL_MASK;
        dwell_q <= '0;
        step_q  <= 1'b0;
      end else if (dwell_q == DWELL_LAST) begin
        sel_q   <= sel_inc;
        y_q     <= oh_inc ^ POL_MASK;
        dwell_q <= '0;
        step_q  <= 1'b1;
      end else begin
        dwell_q <= dwell_q + 1'b1;
        step_q  <= 1'b0;
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.sel  = sel_q;
  assign bus.step = step_q;
endmodule

// File: tb/tb_dec_scan_n.sv
// Scoreboard bench for dec_scan_n: each driven cycle runs a reference model,
// pushes the expected outputs, and pops/compares them after the clock edge.
// Instance A: N=2, DWELL=4, ACTIVE_LOW=0.  Instance B: N=3, DWELL=1, ACTIVE_LOW=1.
module tb_dec_scan_n;
  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  dec_scan_n_if #(.N(2)) bus_a ();
  dec_scan_n_if #(.N(3)) bus_b ();

  dec_scan_n #(.N(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a)
  );

  dec_scan_n #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] y;
    logic [31:0] sel;
    logic [31:0] step;
  } exp_t;

  // st: 0 idle, 1 direct, 2 scan
  typedef struct {
    int st;
    int sel;
    int dw;
    bit act;
    bit stp;
  } mdl_t;

  exp_t sb_q[$];
  mdl_t ma;
  mdl_t mb;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input mdl_t mi, input int nl, input int dwell,
                            input bit en, input bit mode, input bit valid,
                            input int w, output mdl_t mo);
    mo = mi;
    if (!en) begin
      mo.st = 0; mo.act = 1'b0; mo.stp = 1'b0; mo.dw = 0;
    end else if (!mode) begin
      mo.st = 1; mo.dw = 0;
      if (valid) begin
        mo.sel = w; mo.act = 1'b1; mo.stp = 1'b1;
      end else begin
        mo.stp = 1'b0;
      end
    end else begin
      if (mi.st != 2) begin
        mo.act = 1'b1; mo.dw = 0; mo.stp = 1'b0;
      end else if (mi.dw == dwell - 1) begin
        mo.sel = (mi.sel + 1) % nl; mo.dw = 0; mo.stp = 1'b1;
      end else begin
        mo.dw = mi.dw + 1; mo.stp = 1'b0;
      end
      mo.st = 2;
    end
  endtask

  function automatic exp_t expect_of(input string tag, input mdl_t m, input int nl, input bit al);
    exp_t        e;
    logic [31:0] lines;
    lines = m.act ? (32'd1 << m.sel) : 32'd0;
    if (al) lines = ~lines & ((32'd1 << nl) - 32'd1);
    e.tag  = tag;
    e.y    = lines;
    e.sel  = m.sel;
    e.step = {31'd0, m.stp};
    return e;
  endfunction

  task automatic sb_compare(input logic [31:0] y, input logic [31:0] sel, input logic step);
    exp_t e;
    chk("sb_depth", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("[%0t] %s y=%0h sel=%0d step=%0b", $time, e.tag, y, sel, step);
      chk({e.tag, "_y"},    y,             e.y);
      chk({e.tag, "_sel"},  sel,           e.sel);
      chk({e.tag, "_step"}, {31'd0, step}, e.step);
    end
  endtask

  // Drive one clock of stimulus on instance A (b=0) or B (b=1), then check.
  task automatic cycle(input string tag, input bit b, input bit en, input bit mode,
                       input bit valid, input int w);
    mdl_t nx;
    if (!b) begin
      bus_a.en = en; bus_a.mode = mode; bus_a.w_valid = valid; bus_a.w = 2'(w);
      model_step(ma, 4, 4, en, mode, valid, w, nx);
      ma = nx;
      sb_q.push_back(expect_of(tag, ma, 4, 1'b0));
    end else begin
      bus_b.en = en; bus_b.mode = mode; bus_b.w_valid = valid; bus_b.w = 3'(w);
      model_step(mb, 8, 1, en, mode, valid, w, nx);
      mb = nx;
      sb_q.push_back(expect_of(tag, mb, 8, 1'b1));
    end
    @(posedge clk);
    #1;
    if (!b) sb_compare(32'(bus_a.y), 32'(bus_a.sel), bus_a.step);
    else    sb_compare(32'(bus_b.y), 32'(bus_b.sel), bus_b.step);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ma = '{default: 0};
    mb = '{default: 0};
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.w_valid = 1'b0; bus_a.w = '0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.w_valid = 1'b0; bus_b.w = '0;
    #1;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    sb_q.push_back(expect_of("reset", ma, 4, 1'b0));
    sb_compare(32'(bus_a.y), 32'(bus_a.sel), bus_a.step);
    chk("reset_b_y", 32'(bus_b.y), 32'hFF);
    chk("reset_ready", {31'd0, bus_a.w_ready}, 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // DIRECT back-to-back transfers
    for (int i = 0; i < 4; i++) cycle($sformatf("t2_w%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, i);
    chk("t2_y3_const", 32'(bus_a.y), 32'b1000);
    chk("t2_ready", {31'd0, bus_a.w_ready}, 32'd1);
    cycle("t2_hold", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle("t2_hold", 1'b0, 1'b1, 1'b0, 1'b0, 2);

    // SCAN from sel=0 including wrap
    cycle("t3_load0", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 18; i++) cycle("t3_scan", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("t3_ready", {31'd0, bus_a.w_ready}, 32'd0);

    // Disable mid-SCAN at sel=2, then resume
    for (int k = 0; k < 20 && ma.sel != 2; k++) cycle("t4_seek", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle("t4_dwell", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle("t4_off", 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("t4_sel_held", 32'(bus_a.sel), 32'd2);
    chk("t4_y_off", 32'(bus_a.y), 32'd0);
    cycle("t4_resume", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("t4_y_resume", 32'(bus_a.y), 32'b0100);
    for (int i = 0; i < 4; i++) cycle("t4_scan", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("t4_adv", 32'(bus_a.y), 32'b1000);

    // Mode switch mid-dwell; w_valid while not ready is ignored
    for (int k = 0; k < 20 && !(ma.sel == 0 && ma.stp); k++) cycle("t5_seek", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle("t5_dwell", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle("t5_ignored", 1'b0, 1'b1, 1'b1, 1'b1, 3);
    chk("t5_no_xfer", 32'(bus_a.y), 32'b0001);
    cycle("t5_xfer", 1'b0, 1'b1, 1'b0, 1'b1, 3);
    chk("t5_y_const", 32'(bus_a.y), 32'b1000);
    cycle("t5_idle_dir", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle("t5_rescan", 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // Asynchronous reset mid-SCAN at y=0100
    for (int k = 0; k < 20 && ma.sel != 2; k++) cycle("t1_seek", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle("t1_dwell", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("t1_pre_y", 32'(bus_a.y), 32'b0100);
    #2;
    rst_a_n = 1'b0;
    #1;
    ma = '{default: 0};
    sb_q.push_back(expect_of("t1_async", ma, 4, 1'b0));
    sb_compare(32'(bus_a.y), 32'(bus_a.sel), bus_a.step);
    #2;
    rst_a_n = 1'b1;
    cycle("t1_post", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle("t1_post", 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // ACTIVE_LOW, DWELL=1, N=3: advance every cycle with wrap
    for (int i = 0; i < 11; i++) cycle("t6_scan", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("t6_step", {31'd0, bus_b.step}, 32'd1);
    chk("t6_y", 32'(bus_b.y), 32'hFB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
